// File: rtl/astable_multivibrator_nch.sv
// Multi-channel astable multivibrator. Each channel is a free-running square-wave
// oscillator with programmable high time, low time, enable and start level. All
// timing is in clk cycles. A shared single-cycle write port updates the registers,
// and a shared sync strobe phase-aligns all enabled channels.
module astable_multivibrator_nch #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned AW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [1:0]     wr_sel,
  input  logic [CW-1:0]  wr_data,
  input  logic           sync,
  output logic [NCH-1:0] osc_out,
  output logic [NCH-1:0] rise_pulse,
  output logic [NCH-1:0] active
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  localparam logic [1:0] SelTh   = 2'd0;
  localparam logic [1:0] SelTl   = 2'd1;
  localparam logic [1:0] SelCtrl = 2'd2;

  // Counter load value for a duration register; zero behaves as one cycle.
  function automatic logic [CW-1:0] dur_m1(input logic [CW-1:0] d);
    return (d == '0) ? '0 : d - CW'(1);
  endfunction

  logic [CW-1:0]  th_q   [NCH];
  logic [CW-1:0]  th_d   [NCH];
  logic [CW-1:0]  tl_q   [NCH];
  logic [CW-1:0]  tl_d   [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] ph_q, ph_d;
  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [NCH-1:0] osc_q, osc_d;
  logic [NCH-1:0] rise_q, rise_d;

  // Register write decode; addresses at or above NCH and the reserved select fall through.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      th_d[i] = th_q[i];
      tl_d[i] = tl_q[i];
      en_d[i] = en_q[i];
      ph_d[i] = ph_q[i];
      if (wr_en && (32'(wr_addr) == i)) begin
        case (wr_sel)
          SelTh:   th_d[i] = wr_data;
          SelTl:   tl_d[i] = wr_data;
          SelCtrl: begin
            en_d[i] = wr_data[0];
            ph_d[i] = wr_data[1];
          end
          default: ;
        endcase
      end
    end
  end

  // Per-channel phase FSM. Uses pre-edge register values, so a same-edge write
  // only takes effect from the following load. Priority: disable, sync/start, count.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!en_q[i]) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else if (sync || (state_q[i] == StIdle)) begin
        if (ph_q[i]) begin
          state_d[i] = StHigh;
          cnt_d[i]   = dur_m1(th_q[i]);
        end else begin
          state_d[i] = StLow;
          cnt_d[i]   = dur_m1(tl_q[i]);
        end
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else if (state_q[i] == StHigh) begin
        state_d[i] = StLow;
        cnt_d[i]   = dur_m1(tl_q[i]);
      end else begin
        state_d[i] = StHigh;
        cnt_d[i]   = dur_m1(th_q[i]);
      end
      osc_d[i]  = (state_d[i] == StHigh);
      // A HIGH->HIGH sync restart keeps osc high and therefore gives no pulse.
      rise_d[i] = osc_d[i] & ~osc_q[i];
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        th_q[i]    <= CW'(1);
        tl_q[i]    <= CW'(1);
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      en_q   <= '0;
      ph_q   <= '1;
      osc_q  <= '0;
      rise_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        th_q[i]    <= th_d[i];
        tl_q[i]    <= tl_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q   <= en_d;
      ph_q   <= ph_d;
      osc_q  <= osc_d;
      rise_q <= rise_d;
    end
  end

  assign osc_out    = osc_q;
  assign rise_pulse = rise_q;
  assign active     = en_q;

endmodule

// File: tb/tb_astable_multivibrator_nch.sv
// Directed bench for astable_multivibrator_nch with hand-computed waveforms.
module tb_astable_multivibrator_nch;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 3;

  logic           clk;
  logic           rst_n;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [1:0]     wr_sel;
  logic [CW-1:0]  wr_data;
  logic           sync;
  logic [NCH-1:0] osc_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] active;

  int pass_cnt  = 0;
  int total_cnt = 0;

  astable_multivibrator_nch #(
    .NCH(NCH),
    .CW (CW),
    .AW (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .sync      (sync),
    .osc_out   (osc_out),
    .rise_pulse(rise_pulse),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int sel, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_sel  = 2'(sel);
    wr_data = CW'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  // Tick n times; bit j of o/r is the expected level on tick j+1 for every masked channel.
  task automatic seq(input string tag, input logic [NCH-1:0] mask, input int n,
                     input logic [31:0] o, input logic [31:0] r);
    for (int j = 0; j < n; j++) begin
      tick();
      check({tag, "_osc"}, 32'(osc_out & mask), o[j] ? 32'(mask) : 32'd0);
      check({tag, "_rise"}, 32'(rise_pulse & mask), r[j] ? 32'(mask) : 32'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_sel  = '0;
    wr_data = '0;
    sync    = 1'b0;
    tick();
    tick();
    check("rst_osc", 32'(osc_out), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    rst_n = 1'b1;
    tick();

    // Default TH=TL=1: period 2 once enabled.
    wr(0, 2, 3);
    check("ch0_en_active", 32'(active), 32'h1);
    check("ch0_en_osc", 32'(osc_out[0]), 32'd0);
    seq("ch0_default", 4'b0001, 4, 32'b0101, 32'b0101);

    // Asymmetric 3/5 on ch1.
    wr(1, 0, 3);
    wr(1, 1, 5);
    wr(1, 2, 3);
    seq("ch1_asym", 4'b0010, 9, 32'b100000111, 32'b100000001);
    seq("ch1_pre_low", 4'b0010, 3, 32'b011, 32'b000);
    // TL 5->2 written one cycle into a 5-cycle LOW.
    wr(1, 1, 2);
    check("ch1_midlow_osc", 32'(osc_out[1]), 32'd0);
    seq("ch1_tl_update", 4'b0010, 9, 32'b100111000, 32'b100001000);
    // TH=0 behaves as 1 from the next HIGH entry.
    wr(1, 0, 0);
    check("ch1_th0_osc", 32'(osc_out[1]), 32'd1);
    seq("ch1_th0", 4'b0010, 7, 32'b1001001, 32'b1001000);

    // Disable during HIGH.
    wr(1, 0, 3);
    seq("ch1_th3", 4'b0010, 2, 32'b10, 32'b10);
    wr(1, 2, 0);
    check("ch1_dis_active", 32'(active[1]), 32'd0);
    check("ch1_dis_osc_lat", 32'(osc_out[1]), 32'd1);
    tick();
    check("ch1_dis_osc", 32'(osc_out[1]), 32'd0);
    check("ch1_dis_rise", 32'(rise_pulse[1]), 32'd0);

    // Start low on ch2.
    wr(2, 0, 2);
    wr(2, 1, 4);
    wr(2, 2, 1);
    check("ch2_en_active", 32'(active[2]), 32'd1);
    seq("ch2_ph0", 4'b0100, 7, 32'b0110000, 32'b0010000);

    // Sync alignment: ch0 and ch3 at 4/4 started 3 cycles apart.
    wr(0, 2, 0);
    wr(0, 0, 4);
    wr(0, 1, 4);
    wr(3, 0, 4);
    wr(3, 1, 4);
    wr(0, 2, 3);
    tick();
    tick();
    wr(3, 2, 3);
    tick();
    tick();
    tick();
    check("pre_sync_ch0", 32'(osc_out[0]), 32'd0);
    check("pre_sync_ch3", 32'(osc_out[3]), 32'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_osc", 32'(osc_out & 4'b1001), 32'h9);
    check("sync_rise", 32'(rise_pulse & 4'b1001), 32'h1);
    check("sync_disabled_idle", 32'(osc_out[1]), 32'd0);
    seq("sync_aligned", 4'b1001, 8, 32'b10000111, 32'b10000000);

    // Out-of-range address and reserved select are ignored.
    wr(5, 2, 3);
    check("bad_addr", 32'(active), 32'hd);
    wr(1, 3, 3);
    check("bad_sel", 32'(active), 32'hd);

    // Asynchronous reset mid-phase clears outputs before any edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_osc", 32'(osc_out), 32'd0);
    check("arst_rise", 32'(rise_pulse), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(1, 2, 3);
    seq("post_rst_period2", 4'b0010, 4, 32'b0101, 32'b0101);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/astable_multivibrator_nch.md
Name: astable_multivibrator_nch

Overview:
- Parametrised, multi-channel successor to the team's astable multivibrator top.
- Each of NCH channels is a free-running square-wave oscillator with independently programmable high time, low time, enable and start phase. All timing is in clk cycles.
- Configuration comes through a simple single-cycle register write port driven from the tile's ui_in/uio_in pins. Outputs drive uo_out directly.

Parameters:
- NCH, 4, number of oscillator channels (1..8).
- CW, 8, width of the high-time and low-time registers and of each channel's down-counter.
- AW, 2, channel address width; must satisfy 2**AW >= NCH.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  register write strobe, sampled on the rising edge of clk
- wr_addr  input  AW  channel select for the write
- wr_sel  input  2  target register: 0=TH, 1=TL, 2=CTRL, 3=reserved (write ignored)
- wr_data  input  CW  write data; for CTRL, bit0=EN and bit1=PH (start level)
- sync  input  1  phase-restart strobe applied to all enabled channels
- osc_out  output  NCH  registered oscillator outputs
- rise_pulse  output  NCH  one-cycle pulse on the cycle osc_out[i] becomes 1
- active  output  NCH  per-channel EN register readback

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert, synchronous deassert (external synchroniser). Polarity is active-low.
- Reset values: TH=1, TL=1, EN=0, PH=1, state=IDLE, cnt=0, osc_out=0, rise_pulse=0, active=0.
- Effective durations: eth = (TH==0) ? 1 : TH. etl = (TL==0) ? 1 : TL. Zero is never a legal duration.
- Writes: when wr_en=1 and wr_addr<NCH, the addressed register updates at the edge. Writes with wr_addr>=NCH or wr_sel=3 are ignored.
- TH/TL writes do not disturb a running phase. The new value is used at the next phase load.
- Per-channel FSM states: IDLE, HIGH, LOW. osc_out[i] = (state==HIGH), registered.
- IDLE, EN=1: next edge enters HIGH if PH=1, else LOW. The counter loads eth-1 or etl-1 respectively.
- HIGH, cnt!=0: cnt decrements.
- HIGH, cnt==0: go to LOW, load cnt = etl-1.
- LOW, cnt!=0: cnt decrements.
- LOW, cnt==0: go to HIGH, load cnt = eth-1.
- Resulting waveform: osc_out is high exactly eth cycles and low exactly etl cycles; period = eth+etl.
- Any state with EN=0 goes to IDLE at the next edge, with cnt=0 and osc_out=0. Disable mid-phase therefore truncates the phase immediately.
- Enable latency: a CTRL write with EN=1 at edge k gives active=1 from edge k and the first phase entered at edge k+1.
- sync=1: every channel with EN=1, including those in IDLE, enters its PH start state at that edge and loads the full duration. All synced channels become phase-aligned.
- Priority: sync has priority over normal counting. EN=0 has priority over sync.
- Same-edge write and sync (or phase load) on one channel: the load uses the register value held before the edge (old TH/TL/PH).
- rise_pulse[i]: high for exactly the one cycle in which osc_out[i] goes 0->1. This includes entry from IDLE and a sync-forced HIGH.
- No pulse is generated for a HIGH->HIGH sync restart.
- Counter arithmetic: unsigned CW-bit. A load value of at most 2**CW-2 means no wrap is possible.
- Channels are fully independent apart from the shared write port and sync.

Test Plan:
- Reset default: after reset, write CTRL ch0 = 0b11 -> osc_out[0] toggles every cycle (1,0,1,0...), period 2, rise_pulse[0] on every high cycle.
- Asymmetric timing: ch1 TH=3, TL=5, CTRL=0b11 -> osc_out[1] high 3 cycles, low 5 cycles, period 8. TH=0 afterwards -> high 1 cycle from the next HIGH entry.
- Start phase: ch2 TH=2, TL=4, CTRL=0b01 (PH=0) -> the first 4 cycles after entry are low, then high 2, and no rise_pulse until the first high.
- Mid-phase update: change ch1 TL from 5 to 2 during LOW -> the current low phase still lasts 5 cycles and the next low lasts 2.
- Sync alignment: ch0 TH=4/TL=4 and ch3 TH=4/TL=4 started 3 cycles apart; pulse sync -> both rise at the same edge, outputs identical thereafter, no pulse on a channel already entering HIGH.
- Disable/reset mid-operation: write CTRL ch1 = 0 during HIGH -> osc_out[1]=0 at the next edge and active[1]=0. Assert rst_n=0 asynchronously mid-phase -> all outputs 0 immediately, and TH/TL read back to 1 on restart (period 2). A write to wr_addr=5 with NCH=4 (AW=3) has no effect.
